rs_syndrome_calc: RTL and testbench



---
 rtl/rs_syndrome_calc.sv | 133 +++++++++++++
 tb/tb_rs_syndrome_calc.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rs_syndrome_calc.sv
// Reed-Solomon syndrome calculator.
// Evaluates a received codeword, highest-degree symbol first, at alpha^1..alpha^NSYM
// with one Horner accumulator per syndrome. The completed syndrome set is held on a
// valid/ready output until the downstream key-equation solver takes it.
module rs_syndrome_calc #(
    parameter int unsigned N         = 255,
    parameter int unsigned NSYM      = 16,
    parameter logic [8:0]  PRIM_POLY = 9'h11D
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [7:0]        s_data,
    input  logic              s_last,
    output logic              synd_valid,
    input  logic              synd_ready,
    output logic [8*NSYM-1:0] synd_data,
    output logic              synd_nonzero,
    output logic              len_err
);

    localparam int unsigned CNT_W = $clog2(N + 1);

    typedef enum logic [0:0] {
        StAcc,
        StHold
    } state_e;

    // Multiply by alpha (x) modulo the field polynomial.
    function automatic logic [7:0] gf_xtime(input logic [7:0] a);
        gf_xtime = {a[6:0], 1'b0} ^ ({8{a[7]}} & PRIM_POLY[7:0]);
    endfunction

    // Shift-and-add GF(2^8) product; with a constant b it reduces to a fixed XOR network.
    function automatic logic [7:0] gf_const_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] prod;
        logic [7:0] term;
        prod = 8'h00;
        term = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                prod = prod ^ term;
            end
            term = gf_xtime(term);
        end
        gf_const_mul = prod;
    endfunction

    // alpha^e, evaluated at elaboration to produce each accumulator's root constant.
    function automatic logic [7:0] gf_alpha_pow(input int unsigned e);
        logic [7:0] p;
        p = 8'h01;
        for (int unsigned i = 0; i < e; i++) begin
            p = gf_xtime(p);
        end
        gf_alpha_pow = p;
    endfunction

    state_e              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [7:0]          acc_q [NSYM];
    logic [7:0]          acc_d [NSYM];
    logic [8*NSYM-1:0]   acc_d_flat;

    logic                accept;
    logic                first_sym;
    logic                at_max_len;
    logic                close;

    assign s_ready    = (state_q == StAcc);
    assign accept     = s_valid & s_ready;
    assign first_sym  = (cnt_q == '0);
    assign at_max_len = (cnt_q == CNT_W'(N - 1));
    // A frame closes on s_last, or is forced closed when it reaches N symbols.
    assign close      = accept & (s_last | at_max_len);

    // Horner step per syndrome: S_j <- S_j * alpha^j + r. The first symbol seeds S_j
    // directly so no explicit clear is needed between frames.
    for (genvar j = 0; j < NSYM; j++) begin : g_synd
        localparam logic [7:0] Root = gf_alpha_pow(j + 1);
        assign acc_d[j] = first_sym ? s_data : (gf_const_mul(acc_q[j], Root) ^ s_data);
        assign acc_d_flat[8*j +: 8] = acc_d[j];
    end

    // Control FSM, accumulators, counter and registered output set.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StAcc;
            cnt_q        <= '0;
            synd_data    <= '0;
            synd_valid   <= 1'b0;
            synd_nonzero <= 1'b0;
            len_err      <= 1'b0;
            for (int i = 0; i < NSYM; i++) begin
                acc_q[i] <= 8'h00;
            end
        end else begin
            unique case (state_q)
                StAcc: begin
                    if (accept) begin
                        for (int i = 0; i < NSYM; i++) begin
                            acc_q[i] <= acc_d[i];
                        end
                        if (close) begin
                            cnt_q        <= '0;
                            synd_data    <= acc_d_flat;
                            synd_nonzero <= |acc_d_flat;
                            len_err      <= ~s_last;
                            synd_valid   <= 1'b1;
                            state_q      <= StHold;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end
                StHold: begin
                    if (synd_ready) begin
                        synd_valid <= 1'b0;
                        state_q    <= StAcc;
                        for (int i = 0; i < NSYM; i++) begin
                            acc_q[i] <= 8'h00;
                        end
                    end
                end
                default: begin
                    state_q <= StAcc;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rs_syndrome_calc.sv
// Testbench for rs_syndrome_calc: randomized frames against a direct polynomial-evaluation
// model (sum of r_i * alpha^(j*i) via log/antilog tables), plus hand-computed literals.
module tb_rs_syndrome_calc;

    localparam int unsigned N    = 255;
    localparam int unsigned NSYM = 16;
    localparam int          W    = 8 * NSYM;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         s_valid = 1'b0;
    logic         s_ready;
    logic [7:0]   s_data = 8'h00;
    logic         s_last = 1'b0;
    logic         synd_valid;
    logic         synd_ready = 1'b0;
    logic [W-1:0] synd_data;
    logic         synd_nonzero;
    logic         len_err;

    rs_syndrome_calc #(
        .N        (N),
        .NSYM     (NSYM),
        .PRIM_POLY(9'h11D)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .s_last      (s_last),
        .synd_valid  (synd_valid),
        .synd_ready  (synd_ready),
        .synd_data   (synd_data),
        .synd_nonzero(synd_nonzero),
        .len_err     (len_err)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    bit   chk_en = 1'b0;
    int   rdy_mode = 1;  // 0 random, 1 hold low, 2 hold high

    logic [7:0] exp_tab [256];
    int         log_tab [256];

    // Reference model state
    logic [7:0]   cur [$];
    bit           m_hold = 1'b0;
    logic [W-1:0] m_data = '0;
    bit           m_nz = 1'b0;
    bit           m_len = 1'b0;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        if (a == 8'h00 || b == 8'h00) return 8'h00;
        return exp_tab[(log_tab[a] + log_tab[b]) % 255];
    endfunction

    // S_j = sum over k of f[k] * alpha^(j * degree(f[k])); f[0] has degree n-1.
    function automatic logic [W-1:0] model_synd(input logic [7:0] f[$]);
        logic [W-1:0] r;
        logic [7:0]   s;
        int           n;
        r = '0;
        n = f.size();
        for (int j = 1; j <= NSYM; j++) begin
            s = 8'h00;
            for (int k = 0; k < n; k++) begin
                s = s ^ gf_mul(f[k], exp_tab[(j * (n - 1 - k)) % 255]);
            end
            r[8*(j-1) +: 8] = s;
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", name, got, exp, $time);
        end
    endtask

    // Model tables, model self-pin, then per-cycle compare and model update.
    initial begin
        logic [7:0]   x;
        logic [7:0]   pin_q [$];
        logic [W-1:0] pin_r;
        x = 8'h01;
        for (int e = 0; e < 255; e++) begin
            exp_tab[e] = x;
            log_tab[x] = e;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1D : 8'h00);
        end
        exp_tab[255] = 8'h01;
        log_tab[0]   = 0;
        pin_q = {8'h01, 8'h00};
        pin_r = model_synd(pin_q);
        check("model_pin_a", W'(pin_r[71:0]), W'(72'h3A_1D_80_40_20_10_08_04_02));
        pin_q = {8'h00, 8'h01};
        pin_r = model_synd(pin_q);
        check("model_pin_b", pin_r, {NSYM{8'h01}});
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("s_ready", W'(s_ready), W'(!m_hold));
                check("synd_valid", W'(synd_valid), W'(m_hold));
                check("synd_data", synd_data, m_data);
                check("synd_nonzero", W'(synd_nonzero), W'(m_nz));
                check("len_err", W'(len_err), W'(m_len));
            end
            if (rst) begin
                cur.delete();
                m_hold = 1'b0;
                m_data = '0;
                m_nz   = 1'b0;
                m_len  = 1'b0;
            end else if (!m_hold) begin
                if (s_valid) begin
                    cur.push_back(s_data);
                    if (s_last || cur.size() == N) begin
                        m_data = model_synd(cur);
                        m_nz   = (m_data != '0);
                        m_len  = !s_last;
                        m_hold = 1'b1;
                        cur.delete();
                    end
                end
            end else if (synd_ready) begin
                m_hold = 1'b0;
            end
        end
    end

    // Random downstream readiness when enabled.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (rdy_mode == 0) synd_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rdy(input int mode);
        rdy_mode = mode;
        if (mode != 0) synd_ready = (mode == 2);
    endtask

    task automatic wait_accept();
        int n;
        bit ok;
        n  = 0;
        ok = 1'b0;
        do begin
            @(negedge clk);
            ok = s_ready;
            step();
            n++;
        end while (!ok && n < 2000);
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout got s_ready=0 want 1 within 2000 cycles");
        end
    endtask

    task automatic send_frame(input logic [7:0] f[$], input bit use_last, input bit gaps);
        for (int i = 0; i < f.size(); i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                s_valid = 1'b0;
                s_data  = 8'($urandom);
                s_last  = 1'($urandom);
                step();
            end
            s_valid = 1'b1;
            s_data  = f[i];
            s_last  = use_last && (i == f.size() - 1);
            wait_accept();
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (synd_valid !== 1'b1 && n < 600);
        if (synd_valid !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout got synd_valid=%b want 1", name, synd_valid);
        end
    endtask

    task automatic release_out();
        int n;
        step();
        set_rdy(2);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (synd_valid !== 1'b0 && n < 50);
        step();
        set_rdy(1);
    endtask

    initial begin
        logic [7:0] f [$];
        rst = 1'b1;
        set_rdy(1);
        repeat (3) @(posedge clk);
        #1;
        rst    = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        check("rst_valid", W'(synd_valid), '0);
        check("rst_data", synd_data, '0);
        check("rst_ready", W'(s_ready), W'(1'b1));
        step();

        // All-zero full-length frame with s_last on the 255th symbol.
        f.delete();
        for (int i = 0; i < 255; i++) f.push_back(8'h00);
        send_frame(f, 1'b1, 1'b0);
        wait_valid("zero");
        check("zero_data", synd_data, '0);
        check("zero_nz", W'(synd_nonzero), '0);
        check("zero_len", W'(len_err), '0);
        release_out();

        // [01, 00] gives S_j = alpha^j.
        f = {8'h01, 8'h00};
        send_frame(f, 1'b1, 1'b0);
        wait_valid("alpha");
        check("alpha_s1_s9", W'(synd_data[71:0]), W'(72'h3A_1D_80_40_20_10_08_04_02));
        check("alpha_nz", W'(synd_nonzero), W'(1'b1));
        release_out();

        f = {8'h00, 8'h01};
        send_frame(f, 1'b1, 1'b0);
        wait_valid("ones2");
        check("ones2_data", synd_data, {NSYM{8'h01}});
        check("ones2_len", W'(len_err), '0);
        release_out();

        // Single-symbol frame, then hold it under backpressure.
        f = {8'h01};
        send_frame(f, 1'b1, 1'b0);
        wait_valid("ones1");
        check("ones1_data", synd_data, {NSYM{8'h01}});
        check("ones1_nz", W'(synd_nonzero), W'(1'b1));
        step();
        for (int i = 0; i < 10; i++) begin
            s_valid = 1'b1;
            s_data  = 8'($urandom);
            s_last  = 1'($urandom);
            @(negedge clk);
            check("bp_ready", W'(s_ready), '0);
            check("bp_data", synd_data, {NSYM{8'h01}});
            step();
        end
        s_data = 8'hA5;
        s_last = 1'b1;
        set_rdy(2);
        step();
        @(negedge clk);
        check("bubble_ready", W'(s_ready), W'(1'b1));
        step();
        s_valid = 1'b0;
        s_last  = 1'b0;
        set_rdy(1);
        wait_valid("bp_next");
        check("bp_next_data", synd_data, {NSYM{8'hA5}});
        release_out();

        // Overlength: 255 symbols without s_last.
        f.delete();
        for (int i = 0; i < 255; i++) f.push_back(8'($urandom_range(1, 255)));
        send_frame(f, 1'b0, 1'b0);
        wait_valid("over");
        check("over_len", W'(len_err), W'(1'b1));
        release_out();
        f = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        send_frame(f, 1'b1, 1'b0);
        wait_valid("after_over");
        check("after_over_len", W'(len_err), '0);
        release_out();

        // Reset mid-frame discards the partial frame.
        f.delete();
        for (int i = 0; i < 100; i++) f.push_back(8'($urandom_range(1, 255)));
        send_frame(f, 1'b0, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        f = {8'h01, 8'h00};
        send_frame(f, 1'b1, 1'b0);
        wait_valid("post_rst");
        check("post_rst_s1", W'(synd_data[7:0]), W'(8'h02));
        // Reset during HOLD.
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        check("rst_hold_valid", W'(synd_valid), '0);
        check("rst_hold_data", synd_data, '0);
        step();

        // Randomized frames with idle gaps and random downstream readiness.
        set_rdy(0);
        for (int t = 0; t < 25; t++) begin
            f.delete();
            for (int i = 0; i < $urandom_range(1, 60); i++) f.push_back(8'($urandom));
            send_frame(f, 1'b1, 1'b1);
        end
        // Stream longer than N: forced close at 255, remainder is a new frame.
        f.delete();
        for (int i = 0; i < 262; i++) f.push_back(8'($urandom));
        send_frame(f, 1'b1, 1'b1);

        set_rdy(2);
        repeat (10) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
